// File: rtl/servo_sample_sequencer.sv
// Servo sample sequencer: launches one controller sample per PWM frame, captures
// the returned servo command, scales/clamps it to a duty and drives the servo PWM.
module servo_sample_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned PERIOD  = 1000,
    parameter int unsigned NEUTRAL = 500,
    parameter int unsigned SHIFT   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          y_sample_i,
    output logic [WIDTH-1:0]          y_k_o,
    output logic                      dataf_o,
    input  logic                      dataf_i,
    input  logic signed [2*WIDTH-1:0] servo_i,
    output logic [15:0]               duty_o,
    output logic                      pwm_o,
    output logic                      busy_o,
    output logic                      timeout_o
);
    localparam int unsigned CMD_W  = 2 * WIDTH;
    localparam int unsigned SUM_W  = CMD_W + 2;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE} state_e;

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [WAIT_W-1:0]        wait_q, wait_d;
    logic signed [CMD_W-1:0]  cmd_q, cmd_d;
    logic [15:0]              pending_q, pending_d;
    logic [15:0]              duty_q, duty_d;
    logic [WIDTH-1:0]         y_k_q, y_k_d;
    logic                     dataf_q, dataf_d;
    logic                     busy_q, busy_d;
    logic                     timeout_q, timeout_d;
    logic                     pwm_q, pwm_d;

    logic                     boundary;
    logic signed [SUM_W-1:0]  cmd_ext;
    logic signed [SUM_W-1:0]  sum;
    logic [15:0]              duty_calc;

    // Scale the captured command around neutral and clamp into 0..PERIOD.
    always_comb begin
        cmd_ext = SUM_W'(cmd_q);
        sum     = (cmd_ext >>> SHIFT) + $signed(SUM_W'(NEUTRAL));
        if (sum[SUM_W-1]) begin
            duty_calc = '0;
        end else if (sum > $signed(SUM_W'(PERIOD))) begin
            duty_calc = 16'(PERIOD);
        end else begin
            duty_calc = 16'(sum);
        end
    end

    assign boundary = (cnt_q == CNT_W'(PERIOD - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = boundary ? '0 : cnt_q + CNT_W'(1);
        wait_d    = wait_q;
        cmd_d     = cmd_q;
        pending_d = pending_q;
        duty_d    = boundary ? pending_q : duty_q;
        y_k_d     = y_k_q;
        dataf_d   = 1'b0;
        busy_d    = 1'b0;
        timeout_d = timeout_q;
        pwm_d     = (cnt_q < duty_q);

        unique case (state_q)
            S_IDLE: begin
                if (boundary) begin
                    y_k_d   = y_sample_i;
                    state_d = S_LAUNCH;
                    dataf_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_LAUNCH: begin
                wait_d  = '0;
                state_d = S_WAIT;
                busy_d  = 1'b1;
            end
            S_WAIT: begin
                // A done strobe on the expiry clock still counts as a capture.
                if (dataf_i) begin
                    cmd_d   = servo_i;
                    state_d = S_CAPTURE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    busy_d = 1'b1;
                end
            end
            S_CAPTURE: begin
                pending_d = duty_calc;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            cmd_q     <= '0;
            pending_q <= 16'(NEUTRAL);
            duty_q    <= 16'(NEUTRAL);
            y_k_q     <= '0;
            dataf_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            cmd_q     <= cmd_d;
            pending_q <= pending_d;
            duty_q    <= duty_d;
            y_k_q     <= y_k_d;
            dataf_q   <= dataf_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            pwm_q     <= pwm_d;
        end
    end

    assign y_k_o     = y_k_q;
    assign dataf_o   = dataf_q;
    assign duty_o    = duty_q;
    assign pwm_o     = pwm_q;
    assign busy_o    = busy_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_servo_sample_sequencer.sv
// Bench for servo_sample_sequencer: frame-level reference model (per-frame duty,
// sample and done position) checked against the DUT every cycle.
module tb_servo_sample_sequencer;
    localparam int WIDTH   = 8;
    localparam int PERIOD  = 100;
    localparam int NEUTRAL = 50;
    localparam int SHIFT   = 4;
    localparam int TIMEOUT = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   y_sample;
    logic [WIDTH-1:0]   y_k;
    logic               dataf_out;
    logic               dataf_in;
    logic signed [15:0] servo;
    logic [15:0]        duty;
    logic               pwm;
    logic               busy;
    logic               tout;

    servo_sample_sequencer #(
        .WIDTH(WIDTH), .PERIOD(PERIOD), .NEUTRAL(NEUTRAL), .SHIFT(SHIFT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .reset(rst), .y_sample_i(y_sample), .y_k_o(y_k),
        .dataf_o(dataf_out), .dataf_i(dataf_in), .servo_i(servo), .duty_o(duty),
        .pwm_o(pwm), .busy_o(busy), .timeout_o(tout)
    );

    always #5 clk = ~clk;

    // Model state: frame index since reset, position in frame, done position (0 = none).
    int  f, pos, dp, epoch, fcmd, total, bad, pwm_cnt;
    bit  mvalid, was_rst, tout_hist;
    int  fduty[0:15];
    int  fsample[0:15];
    int  dp_a[11] = '{0, 10, 10, 10, 20, 0, -1, -1, -1, -1, 10};
    int  sv_a[5]  = '{0, 160, -2000, 4000, 32};

    function automatic int clampd(input int s);
        int v = NEUTRAL + (s >>> SHIFT);
        if (v < 0) return 0;
        if (v > PERIOD) return PERIOD;
        return v;
    endfunction

    function automatic int pick_dp(input int fr);
        int r;
        if (epoch == 0 && fr <= 10 && dp_a[fr] >= 0) return dp_a[fr];
        r = int'($urandom_range(0, 24));
        return (r > TIMEOUT) ? 0 : r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: frame=%0d pos=%0d got=%0d expected=%0d", name, f, pos, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, clock it, then advance the frame-level model.
    task automatic tick(input bit rst_v);
        logic signed [15:0] sv;
        bit d;
        rst = rst_v;
        y_sample = 8'($urandom);
        if (epoch == 0 && f == 0 && pos == PERIOD - 1) y_sample = 8'h3C;
        if (rst_v && pos == PERIOD - 1) fsample[f + 1] = int'(y_sample);
        sv = 16'($urandom);
        if ($urandom_range(0, 1) == 1) sv = 16'(int'($urandom_range(0, 1600)) - 800);
        d = 1'b0;
        if (f >= 1 && dp > 0 && pos == dp) begin
            if (epoch == 0 && f <= 4) sv = 16'(sv_a[f]);
            fcmd = int'(sv);
            d = 1'b1;
        end else if (f >= 1 && dp > 0 && pos == dp + 1) begin
            d = ($urandom_range(0, 1) == 1);
        end else if (pos >= 40 && $urandom_range(0, 7) == 0) begin
            d = 1'b1;
        end
        if (epoch == 1 && f == 0 && pos == 2) d = 1'b1;
        if (!rst_v) d = ($urandom_range(0, 1) == 1);
        servo = sv;
        dataf_in = d;
        @(posedge clk);
        #1;
        if (!rst_v) begin
            mvalid = 1'b1; was_rst = 1'b1;
            f = 0; pos = 0; tout_hist = 1'b0;
            fduty[0] = NEUTRAL;
            dp = pick_dp(0);
        end else begin
            was_rst = 1'b0;
            if (pos == PERIOD - 1) begin
                fduty[f + 1] = (f >= 1 && dp > 0) ? clampd(fcmd) : fduty[f];
                if (f >= 1 && dp == 0) tout_hist = 1'b1;
                f++; pos = 0;
                dp = pick_dp(f);
            end else begin
                pos++;
            end
        end
    endtask

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin : cmp
        int bend, e_dataf, e_busy, e_tout, e_yk, e_duty, e_pwm;
        if (mvalid) begin
            bend    = (dp == 0) ? TIMEOUT : dp;
            e_dataf = int'(f >= 1 && pos == 0);
            e_busy  = int'(f >= 1 && pos <= bend);
            e_tout  = int'(tout_hist || (f >= 1 && dp == 0 && pos > TIMEOUT));
            e_yk    = (f == 0) ? 0 : fsample[f];
            e_duty  = fduty[f];
            if (pos == 0) e_pwm = int'(f > 0 && fduty[f - 1] == PERIOD);
            else          e_pwm = int'(pos - 1 < fduty[f]);
            chk("dataf_o", int'(dataf_out), e_dataf);
            chk("busy_o", int'(busy), e_busy);
            chk("timeout_o", int'(tout), e_tout);
            chk("y_k_o", int'(y_k), e_yk);
            chk("duty_o", int'(duty), e_duty);
            chk("pwm_o", int'(pwm), e_pwm);

            if (pos == 0) pwm_cnt = 0;
            else          pwm_cnt += int'(pwm);

            if (was_rst) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_duty", int'(duty), 50);
                chk("rst_pwm", int'(pwm), 0);
                chk("rst_timeout", int'(tout), 0);
            end
            if (epoch == 0) begin
                if (f == 1 && pos == 0)  chk("launch_strobe", int'(dataf_out), 1);
                if (f == 1 && pos == 1)  chk("strobe_one_clk", int'(dataf_out), 0);
                if (f == 1 && pos == 15) chk("yk_latched", int'(y_k), 8'h3C);
                if (f == 1 && pos == 99) chk("duty_held_f1", int'(duty), 50);
                if (f == 2 && pos == 50) chk("duty_f2", int'(duty), 60);
                if (f == 3 && pos == 50) chk("duty_f3", int'(duty), 0);
                if (f == 4 && pos == 50) chk("duty_f4", int'(duty), 100);
                if (f == 4 && pos == 30) chk("capture_wins", int'(tout), 0);
                if (f == 5 && pos == 50) chk("duty_f5", int'(duty), 52);
                if (f == 5 && pos == 20) chk("tout_before", int'(tout), 0);
                if (f == 5 && pos == 21) chk("tout_rise", int'(tout), 1);
                if (f == 5 && pos == 21) chk("tout_busy", int'(busy), 0);
                if (f == 6 && pos == 50) chk("duty_f6", int'(duty), 52);
                if (pos == 99 && f == 0) chk("pwm_cnt_f0", pwm_cnt, 50);
                if (pos == 99 && f == 2) chk("pwm_cnt_f2", pwm_cnt, 60);
                if (pos == 99 && f == 3) chk("pwm_cnt_f3", pwm_cnt, 0);
                if (pos == 99 && f == 4) chk("pwm_cnt_f4", pwm_cnt, 99);
            end else begin
                if (f == 0 && pos == 3)  chk("late_done_ignored", int'(busy), 0);
                if (f == 1 && pos == 0)  chk("relaunch", int'(dataf_out), 1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at frame=%0d pos=%0d", f, pos);
        $fatal(1, "watchdog");
    end

    initial begin
        mvalid = 1'b0; was_rst = 1'b0; tout_hist = 1'b0;
        f = 0; pos = 0; dp = 0; epoch = 0; fcmd = 0;
        total = 0; bad = 0; pwm_cnt = 0;
        rst = 1'b0; y_sample = '0; dataf_in = 1'b0; servo = '0;
        for (int i = 0; i < 16; i++) begin
            fduty[i] = NEUTRAL;
            fsample[i] = 0;
        end
        repeat (3) tick(1'b0);
        while (!(f == 10 && pos == 5)) tick(1'b1);
        epoch = 1;
        repeat (3) tick(1'b0);
        while (!(f == 6 && pos == PERIOD - 1)) tick(1'b1);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
